fifo_pop_ctrl: RTL and testbench



---
 rtl/fifo_pop_ctrl.sv | 129 ++++++++++++
 tb/tb_fifo_pop_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_ctrl.sv
// Read-side master for the synchronous FIFO: issues gated pops for a job of
// rd_size words and forwards captured data through a 2-entry skid buffer.
module fifo_pop_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      rd_size,
  output logic             pop,
  input  logic             ept,
  input  logic [WIDTH-1:0] r_data,
  input  logic             valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      words_out
);

  typedef enum logic [1:0] {IDLE, POP, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      remaining_q, remaining_d;
  logic             inflight_q;
  logic [WIDTH-1:0] buf_q [SKID_DEPTH];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      words_q, words_d;

  logic             hs, cap, accept;
  logic [2:0]       occ;

  assign hs     = m_valid && m_ready;
  assign cap    = valid && inflight_q;
  assign accept = (state_q == IDLE) && start;
  // Occupancy after this cycle's handshake; pop only if a slot is guaranteed.
  assign occ    = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, hs};
  assign cnt_d  = cnt_q + {1'b0, cap} - {1'b0, hs};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (rd_size == '0) ? DONE : POP;
      POP:     if (pop && (remaining_q == 32'd1)) state_d = DRAIN;
      // Leave as soon as the last word is handed off this cycle.
      DRAIN:   if (!pop && (cnt_d == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop     = (state_q == POP) && (remaining_q != '0) && !ept && (occ <= 3'd1);
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    m_valid = (cnt_q != '0);
    m_data  = m_valid ? buf_q[rd_ptr_q] : '0;
  end

  always_comb begin
    remaining_d = remaining_q;
    if (accept) begin
      remaining_d = rd_size;
    end else if (pop) begin
      remaining_d = remaining_q - 32'd1;
    end
  end

  always_comb begin
    words_d = words_q;
    if (accept) begin
      words_d = '0;
    end else if (hs && (words_q != '1)) begin
      words_d = words_q + 32'd1;
    end
  end

  always_comb begin
    err_d = accept ? 1'b0 : err_q;
    if (valid && !inflight_q) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      words_q     <= '0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      remaining_q <= remaining_d;
      inflight_q  <= pop;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      words_q     <= words_d;
      if (cap) begin
        buf_q[wr_ptr_q] <= r_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (hs) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign err       = err_q;
  assign words_out = words_q;

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Scoreboard bench for fifo_pop_ctrl: a FIFO model feeds data, a monitor
// compares every presented downstream word against the expected queue.
module tb_fifo_pop_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] rd_size;
  logic        pop;
  logic        ept;
  logic [7:0]  r_data;
  logic        valid;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] words_out;

  fifo_pop_ctrl #(.WIDTH(8), .SKID_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .start(start), .rd_size(rd_size),
    .pop(pop), .ept(ept), .r_data(r_data), .valid(valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err), .words_out(words_out)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic       inj_valid = 1'b0;

  int cyc = 0, pop_cnt = 0, hs_cnt = 0, done_cnt = 0;
  int pop_run = 0, pop_run_max = 0, outstanding = 0;
  int job_hs = 0, first_hs_cyc = 0, last_hs_cyc = 0, done_cyc = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
  endtask

  task automatic do_start(input logic [31:0] n);
    start   = 1'b1;
    rd_size = n;
    tick();
    start   = 1'b0;
    rd_size = '0;
  endtask

  task automatic wait_done(input int n, input string name);
    int base;
    base = done_cnt;
    for (int i = 0; i < n; i++) begin
      if (done_cnt > base) break;
      tick();
    end
    check(name, 32'(done_cnt > base), 32'd1);
  endtask

  // FIFO model: data answers an accepted pop one cycle later.
  initial begin
    logic pop_seen;
    valid  = 1'b0;
    r_data = '0;
    forever begin
      @(negedge clock);
      pop_seen = pop && !reset;
      @(posedge clock);
      #2;
      if (reset) begin
        valid = 1'b0; r_data = '0;
      end else if (inj_valid) begin
        valid = 1'b1; r_data = 8'hA5;
      end else if (pop_seen && (fq.size() > 0)) begin
        valid = 1'b1; r_data = fq.pop_front();
      end else begin
        valid = 1'b0; r_data = '0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        outstanding = 0;
        pop_run     = 0;
        continue;
      end
      if (start && !busy) begin
        job_hs      = 0;
        pop_run_max = 0;
      end
      if (ept) check("pop_while_empty", 32'(pop), 32'd0);
      if (pop) begin
        pop_cnt++;
        pop_run++;
        outstanding++;
        if (pop_run > pop_run_max) pop_run_max = pop_run;
        check("pop_with_data_left", 32'(fq.size() > 0), 32'd1);
      end else begin
        pop_run = 0;
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          check("m_data_order", 32'(m_data), 32'(exp_q[0]));
        end
        if (m_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          hs_cnt++;
          if (job_hs == 0) first_hs_cyc = cyc;
          job_hs++;
          last_hs_cyc = cyc;
          outstanding--;
        end
      end
      if (pop || m_valid) check("occupancy_le_2", 32'(outstanding <= 2), 32'd1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
    $fatal(1);
  end

  initial begin
    int p0, h0, d0;
    reset = 1'b1; start = 1'b0; rd_size = '0; ept = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    check("rst_pop", 32'(pop), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();
    check("rst_m_data", 32'(m_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_words_out", words_out, 0);

    // 1: four words streamed back to back
    load(8'hA0, 4);
    p0 = pop_cnt; h0 = hs_cnt; d0 = done_cnt;
    do_start(4);
    wait_done(40, "t1_done_timeout");
    check("t1_words_out", words_out, 32'd4);
    check("t1_pop_count", 32'(pop_cnt - p0), 32'd4);
    check("t1_pop_consecutive", 32'(pop_run_max), 32'd4);
    check("t1_hs_count", 32'(hs_cnt - h0), 32'd4);
    check("t1_hs_consecutive", 32'(last_hs_cyc - first_hs_cyc), 32'd3);
    check("t1_done_after_last_hs", 32'(done_cyc - last_hs_cyc), 32'd1);
    repeat (3) tick();
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_exp_empty", 32'(exp_q.size()), 32'd0);

    // 2: zero-length job
    p0 = pop_cnt;
    check("t2_idle_busy", 32'(busy), 32'd0);
    do_start(0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy_in_done", 32'(busy), 32'd1);
    tick();
    check("t2_done_cleared", 32'(done), 32'd0);
    check("t2_busy_cleared", 32'(busy), 32'd0);
    check("t2_no_pop", 32'(pop_cnt - p0), 32'd0);

    // 3: back-pressure for 5 cycles
    load(8'hB0, 6);
    m_ready = 1'b0;
    p0 = pop_cnt; h0 = hs_cnt; d0 = done_cnt;
    do_start(6);
    for (int i = 0; i < 20; i++) begin
      if (m_valid) break;
      tick();
    end
    check("t3_m_valid_seen", 32'(m_valid), 32'd1);
    repeat (5) tick();
    check("t3_held_valid", 32'(m_valid), 32'd1);
    check("t3_held_data", 32'(m_data), 32'hB0);
    check("t3_pops_while_stalled", 32'(pop_cnt - p0), 32'd2);
    check("t3_no_handoff", 32'(hs_cnt - h0), 32'd0);
    m_ready = 1'b1;
    wait_done(60, "t3_done_timeout");
    check("t3_words_out", words_out, 32'd6);
    check("t3_exp_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("t3_done_once", 32'(done_cnt - d0), 32'd1);

    // 4: FIFO empty for 3 cycles mid-job
    load(8'hC0, 5);
    p0 = pop_cnt; d0 = done_cnt;
    do_start(5);
    tick();
    check("t4_pops_before_gap", 32'(pop_cnt - p0), 32'd1);
    ept = 1'b1;
    repeat (3) tick();
    check("t4_pops_in_gap", 32'(pop_cnt - p0), 32'd1);
    ept = 1'b0;
    wait_done(60, "t4_done_timeout");
    check("t4_words_out", words_out, 32'd5);
    check("t4_pop_total", 32'(pop_cnt - p0), 32'd5);
    tick();
    check("t4_done_once", 32'(done_cnt - d0), 32'd1);

    // 5: stray valid in IDLE
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    check("t5_err_set", 32'(err), 32'd1);
    check("t5_no_m_valid", 32'(m_valid), 32'd0);
    tick();
    check("t5_err_sticky", 32'(err), 32'd1);
    check("t5_still_no_m_valid", 32'(m_valid), 32'd0);
    load(8'hD0, 1);
    do_start(1);
    check("t5_err_cleared", 32'(err), 32'd0);
    wait_done(40, "t5_done_timeout");
    check("t5_words_out", words_out, 32'd1);

    // 6: reset mid-job, then a fresh job
    load(8'hE0, 5);
    h0 = hs_cnt;
    do_start(5);
    for (int i = 0; i < 30; i++) begin
      if (hs_cnt - h0 >= 2) break;
      tick();
    end
    check("t6_two_words_seen", 32'(hs_cnt - h0 >= 2), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_pop", 32'(pop), 32'd0);
    check("t6_rst_m_valid", 32'(m_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_words_out", words_out, 32'd0);
    fq.delete();
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    check("t6_err_after_reset", 32'(err), 32'd0);
    load(8'hF0, 3);
    d0 = done_cnt;
    do_start(3);
    wait_done(40, "t6_done_timeout");
    check("t6_words_out", words_out, 32'd3);
    check("t6_exp_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("t6_done_once", 32'(done_cnt - d0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
